// File: rtl/root_power.sv
// Fixed-point integer power: out = floor((x/2^FRAC)^n * 2^FRAC) for Q10.10 x and n in 0..7.
// A shift-add multiplier consumes one operand bit per cycle; each of the n-1 multiplies takes W_IN cycles.
module root_power #(
   parameter int FRAC  = 10,
   parameter int W_IN  = 20,
   parameter int W_OUT = 80
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [W_IN-1:0]  in_data_1,
   input  logic [2:0]       in_data_2,
   output logic             out_valid,
   output logic [W_OUT-1:0] out_data
);

   localparam int W_ACC = 7 * W_IN;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] MUL  = 1'b1;
   localparam logic [W_OUT-1:0] ONE = W_OUT'(1) << FRAC;
   localparam logic [4:0] LAST_BIT = 5'(W_IN - 1);

   logic [0:0]       state;
   logic [W_IN-1:0]  xr;
   logic [W_ACC-1:0] acc;
   logic [W_ACC-1:0] prod;
   logic [W_ACC-1:0] prod_nxt;
   logic [W_ACC-1:0] acc_sh;
   logic [4:0]       bit_cnt;
   logic [2:0]       mul_cnt;
   logic [2:0]       n_r;
   logic [6:0]       sh;

   // x^n carries n*FRAC fractional bits; drop (n-1)*FRAC of them at the end only.
   always_comb begin
      prod_nxt = prod;
      if (xr[bit_cnt]) prod_nxt = prod + (acc << bit_cnt);
      sh     = 7'(FRAC) * 7'(n_r - 3'd1);
      acc_sh = acc >> sh;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         xr        <= '0;
         acc       <= '0;
         prod      <= '0;
         bit_cnt   <= '0;
         mul_cnt   <= '0;
         n_r       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (in_valid) begin
                  xr        <= in_data_1;
                  acc       <= W_ACC'(in_data_1);
                  prod      <= '0;
                  bit_cnt   <= '0;
                  n_r       <= in_data_2;
                  mul_cnt   <= (in_data_2 >= 3'd2) ? in_data_2 - 3'd1 : 3'd0;
                  out_data  <= '0;
                  state     <= MUL;
               end
            end
            MUL: begin
               // mul_cnt == 0 means every multiply is done: this edge publishes the result.
               if (mul_cnt == 3'd0) begin
                  out_data  <= (n_r == 3'd0) ? ONE : acc_sh[W_OUT-1:0];
                  out_valid <= 1'b1;
                  state     <= IDLE;
               end else if (bit_cnt == LAST_BIT) begin
                  acc     <= prod_nxt;
                  prod    <= '0;
                  bit_cnt <= '0;
                  mul_cnt <= mul_cnt - 3'd1;
               end else begin
                  prod    <= prod_nxt;
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_root_power.sv
// Self-checking bench for root_power: directed cases, protocol corners, reset abort and random ops
// scored against an independent 140-bit power model through an expected-result queue.
module tb_root_power;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [19:0] in_data_1;
   logic [2:0]  in_data_2;
   logic        out_valid;
   logic [79:0] out_data;

   logic [79:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   root_power dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data_1 (in_data_1),
      .in_data_2 (in_data_2),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [139:0] obs, input logic [139:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [79:0] model(input logic [19:0] x, input logic [2:0] n);
      logic [139:0] p;
      p = 140'd1;
      for (int k = 0; k < int'(n); k++) p = p * 140'(x);
      if (n == 3'd0) return 80'h400;
      return 80'(p >> (10 * (int'(n) - 1)));
   endfunction

   function automatic int lat_of(input logic [2:0] n);
      return (n < 3'd2) ? 1 : 20 * (int'(n) - 1) + 1;
   endfunction

   // Drives one accepted strobe; returns 1 time unit after the accepting edge (edge 0).
   task automatic start_op(input logic [19:0] x, input logic [2:0] n, input logic [79:0] exp);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data_1 = x;
      in_data_2 = n;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_data_1 = 20'($urandom);
      in_data_2 = 3'($urandom);
   endtask

   // Counts edges until out_valid is seen; bounded so a dead DUT still reaches the summary.
   task automatic wait_done(input string tag, input int start, input int exp_lat);
      int  lat;
      bit  got;
      lat = start;
      got = 1'b0;
      while (!got && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) got = 1'b1;
      end
      check({tag, "_lat"}, 140'(lat), 140'(exp_lat));
   endtask

   // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) check("spurious_out_valid", 140'(1), 140'(0));
         else                   check("out_data", 140'(out_data), 140'(exp_q.pop_front()));
      end
   end

   initial begin
      logic [19:0] rx;
      logic [2:0]  rn;
      logic [79:0] held;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data_1 = '0;
      in_data_2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 140'(out_valid), 140'(0));
      check("rst_out_data",  140'(out_data),  140'(0));
      rst_n = 1'b1;

      // n = 0 and n = 1, back-to-back; the second strobe lands in the out_valid cycle.
      start_op(20'h00000, 3'd0, 80'h400);
      wait_done("n0", 0, 1);
      start_op(20'h12345, 3'd1, 80'h12345);
      wait_done("n1", 0, 1);
      start_op(20'h00600, 3'd2, 80'h900);
      check("b2b_valid_drop", 140'(out_valid), 140'(0));
      check("b2b_data_clear", 140'(out_data),  140'(0));
      wait_done("x1p5_n2", 0, 21);
      start_op(20'h00001, 3'd2, 80'h0);
      wait_done("trunc_n2", 0, 21);
      start_op(20'h00400, 3'd7, 80'h400);
      wait_done("one_n7", 0, 121);
      start_op(20'hFFFFF, 3'd7, model(20'hFFFFF, 3'd7));
      wait_done("max_n7", 0, 121);

      // 2.0^3 with a stray strobe mid-multiply; then check the pulse width and data hold.
      start_op(20'h00800, 3'd3, 80'h2000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data_1 = 20'hFFFFF;
      in_data_2 = 3'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done("x2_n3", 11, 41);
      held = out_data;
      @(posedge clk);
      #1;
      check("pulse_one_cycle", 140'(out_valid), 140'(0));
      check("data_held", 140'(out_data), 140'(80'h2000));
      check("data_held_same", 140'(out_data), 140'(held));
      repeat (5) @(posedge clk);

      // Reset at edge 30 of an n=7 run aborts it; the next op starts the following edge.
      start_op(20'h00C00, 3'd7, model(20'h00C00, 3'd7));
      repeat (29) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_out_valid", 140'(out_valid), 140'(0));
      check("abort_out_data",  140'(out_data),  140'(0));
      exp_q.delete();
      rst_n = 1'b1;
      start_op(20'h00A00, 3'd7, model(20'h00A00, 3'd7));
      wait_done("post_reset_n7", 0, 121);

      // Random operands and exponents, issued back-to-back.
      for (int i = 0; i < 400; i++) begin
         rx = 20'($urandom_range(0, 20'hFFFFF));
         rn = 3'($urandom_range(0, 7));
         if (i % 8 == 0) rx = 20'($urandom_range(0, 20'h00FFF));
         start_op(rx, rn, model(rx, rn));
         wait_done("rand", 0, lat_of(rn));
      end

      repeat (3) @(posedge clk);
      check("queue_empty", 140'(exp_q.size()), 140'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
